// File: rtl/indication_output_queue_pkg.sv
// Shared types and helpers for the indication serializer: tag/message packing
// and the tag-width sanity check used at elaboration.
package indication_pkg;

  localparam int DEF_TAG_W     = 4;
  localparam int DEF_PAYLOAD_W = 64;

  typedef logic [DEF_TAG_W-1:0] tag_t;

  typedef struct packed {
    tag_t                     tag;
    logic [DEF_PAYLOAD_W-1:0] payload;
  } msg_t;

  // Tag 0 is reserved so an all-zero word downstream never looks like a message.
  localparam tag_t TAG_INVALID = '0;

  function automatic bit tag_w_ok(input int num_methods, input int tag_w);
    return (num_methods >= 1) && (num_methods < (1 << tag_w));
  endfunction

  function automatic msg_t pack_msg(input tag_t tag, input logic [DEF_PAYLOAD_W-1:0] payload);
    msg_t m;
    m.tag     = tag;
    m.payload = payload;
    return m;
  endfunction

endpackage

// File: rtl/indication_output_queue_fifo.sv
// Registered-storage FIFO; pointers carry an extra wrap bit so full and empty
// are told apart without a separate counter.
module pipe_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   enq,
  input  logic [WIDTH-1:0]       enq_data,
  input  logic                   deq,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_enq;
  logic             do_deq;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count  = wr_ptr - rd_ptr;
  assign head   = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign do_enq = enq & ~full;
  assign do_deq = deq & ~empty;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_deq) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_enq) mem[wr_ptr[AW-1:0]] <= enq_data;
  end

endmodule

// File: rtl/indication_output_queue.sv
// Indication serializer: per-method one-entry slots, round-robin packing of
// {tag, payload} into a FIFO that feeds the single pipe_enq port.
module indication_output_queue
  import indication_pkg::*;
#(
  parameter int NUM_METHODS = 4,
  parameter int PAYLOAD_W   = 64,
  parameter int DEPTH       = 8,
  parameter int TAG_W       = 4
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic [NUM_METHODS-1:0]           indication__ENA,
  input  logic [NUM_METHODS*PAYLOAD_W-1:0] indication_v,
  output logic [NUM_METHODS-1:0]           indication__RDY,
  output logic                             pipe_enq__ENA,
  output logic [TAG_W+PAYLOAD_W-1:0]       pipe_enq_v,
  input  logic                             pipe_enq__RDY,
  output logic [$clog2(DEPTH):0]           count,
  output logic                             proto_err
);

  localparam int RW = (NUM_METHODS > 1) ? $clog2(NUM_METHODS) : 1;
  localparam int MW = TAG_W + PAYLOAD_W;

  if (!tag_w_ok(NUM_METHODS, TAG_W)) begin : g_cfg_err
    $error("indication_output_queue: TAG_W too small for NUM_METHODS");
  end

  // Handshake: a side transfers on any cycle where its ENA is high; ENA may only
  // be raised while the matching RDY is high, and RDY never depends on ENA.
  logic [NUM_METHODS-1:0] slot_valid;
  logic [PAYLOAD_W-1:0]   slot_data [NUM_METHODS];
  logic [RW-1:0]          rr;
  logic [NUM_METHODS-1:0] drain;
  logic [NUM_METHODS-1:0] accept;
  logic                   grant_valid;
  logic [RW-1:0]          grant_idx;
  logic [TAG_W-1:0]       grant_tag;
  logic [MW-1:0]          fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;

  function automatic logic [RW-1:0] rr_index(input logic [RW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_METHODS) s = s - NUM_METHODS;
    return RW'(s);
  endfunction

  // Full is taken from registered occupancy, so a same-cycle dequeue never frees a grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    drain       = '0;
    for (int k = 0; k < NUM_METHODS; k++) begin
      if (!grant_valid && !fifo_full && slot_valid[rr_index(rr, k)]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_index(rr, k);
      end
    end
    if (grant_valid) drain[grant_idx] = 1'b1;
  end

  assign grant_tag       = TAG_W'(int'(grant_idx) + 1);
  assign indication__RDY = ~slot_valid | drain;
  assign accept          = indication__ENA & indication__RDY;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      slot_valid <= '0;
      rr         <= '0;
      proto_err  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_METHODS; i++) begin
        if (accept[i])     slot_valid[i] <= 1'b1;
        else if (drain[i]) slot_valid[i] <= 1'b0;
      end
      if (|(indication__ENA & ~indication__RDY)) proto_err <= 1'b1;
      if (grant_valid) rr <= (int'(grant_idx) == NUM_METHODS - 1) ? '0 : grant_idx + RW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_METHODS; i++) begin
      if (accept[i]) slot_data[i] <= indication_v[i*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  pipe_fifo #(
    .WIDTH (MW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .nRST     (nRST),
    .enq      (grant_valid),
    .enq_data ({grant_tag, slot_data[grant_idx]}),
    .deq      (pipe_enq__ENA),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (count)
  );

  assign pipe_enq__ENA = ~fifo_empty & pipe_enq__RDY;
  assign pipe_enq_v    = fifo_head;

endmodule

// File: tb/tb_indication_output_queue.sv
// Randomized and directed bench for indication_output_queue with a per-method
// expected-payload scoreboard popped by an output monitor.
module tb_indication_output_queue;

  logic         clk;
  logic         nrst;
  logic [3:0]   ind_ena;
  logic [255:0] ind_v;
  logic [3:0]   ind_rdy;
  logic         pipe_ena;
  logic [67:0]  pipe_v;
  logic         pipe_rdy;
  logic [3:0]   count;
  logic         proto_err;

  int total = 0;
  int bad   = 0;
  int n_tx  = 0;
  int n_rx  = 0;
  int n_drop = 0;

  logic [63:0] exp_q[4][$];

  indication_output_queue #(
    .NUM_METHODS (4),
    .PAYLOAD_W   (64),
    .DEPTH       (8),
    .TAG_W       (4)
  ) dut (
    .CLK             (clk),
    .nRST            (nrst),
    .indication__ENA (ind_ena),
    .indication_v    (ind_v),
    .indication__RDY (ind_rdy),
    .pipe_enq__ENA   (pipe_ena),
    .pipe_enq_v      (pipe_v),
    .pipe_enq__RDY   (pipe_rdy),
    .count           (count),
    .proto_err       (proto_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int pending();
    return exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
  endfunction

  // monitor: every emitted message must be the oldest outstanding payload of its method
  always @(negedge clk) begin : monitor
    logic [3:0]  tag;
    logic [63:0] pl;
    if (nrst && pipe_ena) begin
      tag = pipe_v[67:64];
      pl  = pipe_v[63:0];
      n_rx++;
      if (tag == 4'd0 || tag > 4'd4) begin
        chk("tag_range", {124'd0, tag}, 128'd1);
      end else if (exp_q[tag-1].size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_msg: got tag %0d payload %0h expected nothing", tag, pl);
      end else begin
        chk("payload", {64'd0, pl}, {64'd0, exp_q[tag-1].pop_front()});
      end
    end
  end

  // driver: present mask/vals for one cycle; accepted entries go to the scoreboard
  task automatic issue(input logic [3:0] mask, input logic [255:0] vals);
    ind_ena = mask;
    ind_v   = vals;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        exp_q[i].push_back(vals[i*64 +: 64]);
        n_tx++;
      end
    end
    @(posedge clk);
    #1;
    ind_ena = 4'd0;
  endtask

  function automatic logic [255:0] rand_vals();
    logic [255:0] r;
    for (int i = 0; i < 4; i++) r[i*64 +: 64] = {$urandom, $urandom};
    return r;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain_all(input string nm);
    int cyc;
    cyc = 0;
    pipe_rdy = 1'b1;
    ind_ena  = 4'd0;
    while ((pending() != 0 || count != 4'd0) && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({nm, "_pending"}, pending(), 0);
    chk({nm, "_count"}, {124'd0, count}, 128'd0);
  endtask

  initial begin
    int v;
    logic [255:0] vals;

    nrst     = 1'b0;
    ind_ena  = 4'd0;
    ind_v    = '0;
    pipe_rdy = 1'b1;
    idle(2);
    nrst = 1'b1;

    // reset state and idle stability
    chk("rst_rdy", {124'd0, ind_rdy}, 128'hF);
    chk("rst_pipe_ena", {127'd0, pipe_ena}, 128'd0);
    chk("rst_count", {124'd0, count}, 128'd0);
    chk("rst_pipe_v", {60'd0, pipe_v}, 128'd0);
    chk("rst_proto_err", {127'd0, proto_err}, 128'd0);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("idle_state", {122'd0, ind_rdy, pipe_ena, count[3:0] == 4'd0}, {122'd0, 4'hF, 1'b0, 1'b1});
    end

    // all four methods at once with rr=0: tags 1..4 on consecutive cycles
    issue(4'hF, rand_vals());
    chk("t3_latency", {127'd0, pipe_ena}, 128'd0);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      chk("t3_ena", {127'd0, pipe_ena}, 128'd1);
      chk("t3_tag", {124'd0, pipe_v[67:64]}, 128'(k + 1));
    end
    drain_all("t3");

    // single message latency and packing
    vals = '0;
    vals[2*64 +: 64] = 64'hDEAD_BEEF;
    issue(4'b0100, vals);
    chk("t2_n1_ena", {127'd0, pipe_ena}, 128'd0);
    idle(1);
    chk("t2_ena", {127'd0, pipe_ena}, 128'd1);
    chk("t2_v", {60'd0, pipe_v}, {60'd0, 4'd3, 64'hDEAD_BEEF});
    drain_all("t2");

    // backpressure on method 0: FIFO plus slot absorb DEPTH+1 messages
    pipe_rdy = 1'b0;
    v = 0;
    for (int c = 0; c < 40 && ind_rdy[0] && v < 10; c++) begin
      vals = '0;
      vals[63:0] = 64'(v);
      issue(4'b0001, vals);
      v++;
    end
    chk("t4_accepted", 128'(v), 128'd9);
    chk("t4_count_full", {124'd0, count}, 128'd8);
    chk("t4_rdy0_low", {127'd0, ind_rdy[0]}, 128'd0);
    pipe_rdy = 1'b1;
    for (int c = 0; c < 20 && !ind_rdy[0]; c++) idle(1);
    vals = '0;
    vals[63:0] = 64'd9;
    if (ind_rdy[0]) issue(4'b0001, vals);
    else chk("t4_rdy0_return", {127'd0, ind_rdy[0]}, 128'd1);
    drain_all("t4");

    // protocol error on method 1 while its slot is blocked
    pipe_rdy = 1'b0;
    for (int c = 0; c < 40 && ind_rdy[1]; c++) issue(4'b0010, rand_vals());
    chk("t5_pre_err", {127'd0, proto_err}, 128'd0);
    ind_ena = 4'b0010;
    ind_v   = rand_vals();
    idle(1);
    ind_ena = 4'd0;
    chk("t5_err_set", {127'd0, proto_err}, 128'd1);
    idle(5);
    chk("t5_err_sticky", {127'd0, proto_err}, 128'd1);
    drain_all("t5");

    // randomized traffic with random downstream readiness
    for (int c = 0; c < 400; c++) begin
      pipe_rdy = ($urandom_range(0, 3) != 0);
      issue(4'($urandom_range(0, 15)) & ind_rdy, rand_vals());
    end
    drain_all("rand");
    chk("rand_err_still", {127'd0, proto_err}, 128'd1);

    // reset mid-operation discards slots and FIFO contents
    pipe_rdy = 1'b0;
    for (int c = 0; c < 40 && count != 4'd5; c++) issue(4'b0011 & ind_rdy, rand_vals());
    chk("t6_pre_count", {124'd0, count}, 128'd5);
    chk("t6_pre_slots", {126'd0, ind_rdy[1:0] != 2'b11}, 128'd1);
    nrst = 1'b0;
    n_drop += pending();
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    idle(1);
    nrst     = 1'b1;
    pipe_rdy = 1'b1;
    #1;
    chk("t6_count", {124'd0, count}, 128'd0);
    chk("t6_rdy", {124'd0, ind_rdy}, 128'hF);
    chk("t6_pipe_ena", {127'd0, pipe_ena}, 128'd0);
    chk("t6_err_clr", {127'd0, proto_err}, 128'd0);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("t6_quiet", {127'd0, pipe_ena}, 128'd0);
    end

    for (int c = 0; c < 100; c++) begin
      pipe_rdy = ($urandom_range(0, 1) != 0);
      issue(4'($urandom_range(0, 15)) & ind_rdy, rand_vals());
    end
    drain_all("post_rst");
    chk("rx_total", 128'(n_rx), 128'(n_tx - n_drop));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
